// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller: decodes the stage1 instruction, tracks EX/MEM/WB destinations,
// and drives the load-use stall, the operand forwarding selects and saturating performance counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [15:0]      IR,
    input  logic             Id_valid,
    output logic             Stall,
    output logic [2:0]       Forw_a_ctrl,
    output logic [2:0]       Forw_b_ctrl,
    input  logic             Cnt_clr,
    output logic [CNT_W-1:0] Stall_cnt,
    output logic [CNT_W-1:0] Fwd_cnt
);

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0, OP_ADD  = 4'h1, OP_SUB   = 4'h2, OP_AND   = 4'h3,
        OP_OR    = 4'h4, OP_XOR  = 4'h5, OP_SHL   = 4'h6, OP_SHR   = 4'h7,
        OP_LOADI = 4'h8, OP_LOAD = 4'h9, OP_STORE = 4'hA, OP_JMP   = 4'hB,
        OP_BRZ   = 4'hC, OP_BRNZ = 4'hD, OP_INOUT = 4'hE, OP_MOV   = 4'hF
    } opcode_e;

    typedef struct packed {
        logic       vld;
        logic       we;
        logic       is_load;
        logic [2:0] dest;
    } sb_entry_t;

    sb_entry_t ex_q, mem_q, wb_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;

    opcode_e    opcode;
    logic [2:0] src_a, src_b;
    logic       dec_we, dec_load, use_a, use_b;
    logic       stall_raw, fwd_any;
    logic       unused_bits;

    assign opcode = opcode_e'(IR[15:12]);
    assign src_a  = IR[8:6];
    assign src_b  = IR[5:3];
    assign unused_bits = ^{IR[2:1], wb_q.is_load};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec_we   = 1'b1;
        use_a    = 1'b1;
        use_b    = 1'b1;
        dec_load = (opcode == OP_LOAD);
        case (opcode)
            OP_JMP, OP_BRZ, OP_BRNZ, OP_STORE, OP_NOP: dec_we = 1'b0;
            OP_INOUT:                                  dec_we = ~IR[0];
            default:                                   ;
        endcase
        if (opcode inside {OP_LOADI, OP_NOP})
            use_a = 1'b0;
        if (opcode == OP_NOP || (opcode inside {OP_LOAD, OP_STORE} && IR[0]))
            use_b = 1'b0;
        dec_we   = dec_we   & Id_valid;
        dec_load = dec_load & Id_valid;
        use_a    = use_a    & Id_valid;
        use_b    = use_b    & Id_valid;
    end

    function automatic logic hit(input sb_entry_t e, input logic use_x, input logic [2:0] src);
        return use_x & e.vld & e.we & (e.dest == src);
    endfunction

    // Youngest producer wins; a load still in EX has no data yet, so it falls through to MEM/WB.
    function automatic logic [2:0] fwd_sel(input sb_entry_t ex, input sb_entry_t mem,
                                           input sb_entry_t wb, input logic use_x,
                                           input logic [2:0] src);
        if (hit(ex, use_x, src) && !ex.is_load) return 3'd1;
        if (hit(mem, use_x, src))               return 3'd2;
        if (hit(wb, use_x, src))                return 3'd3;
        return 3'd0;
    endfunction

    assign stall_raw   = ex_q.is_load & (hit(ex_q, use_a, src_a) | hit(ex_q, use_b, src_b));
    assign Stall       = Rst_n & stall_raw;
    assign Forw_a_ctrl = Rst_n ? fwd_sel(ex_q, mem_q, wb_q, use_a, src_a) : 3'd0;
    assign Forw_b_ctrl = Rst_n ? fwd_sel(ex_q, mem_q, wb_q, use_b, src_b) : 3'd0;
    assign fwd_any     = ((Forw_a_ctrl != 3'd0) | (Forw_b_ctrl != 3'd0)) & ~Stall;

    always_comb begin
        ex_d = '0;
        if (!Stall && Id_valid) begin
            ex_d.vld     = 1'b1;
            ex_d.we      = dec_we;
            ex_d.is_load = dec_load;
            ex_d.dest    = IR[11:9];
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (Cnt_clr) begin
            stall_cnt_d = '0;
            fwd_cnt_d   = '0;
        end else begin
            if (Stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (fwd_any && fwd_cnt_q != '1) fwd_cnt_d   = fwd_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so the EX->MEM->WB shift reads old values.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign Stall_cnt = stall_cnt_q;
    assign Fwd_cnt   = fwd_cnt_q;

endmodule
